// File: rtl/memory_unit.sv
// Data-memory responder: one Wishbone B4 classic cycle per load/store, with
// lane steering, load extension and misalignment / bus-error reporting.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for rd_en/wr_en; busy follows the request
// BUS   | Wishbone cycle open, bus outputs frozen until ack or err
// DONE  | one-cycle completion pulse after the bus cycle
// FAULT | one-cycle completion pulse for a misaligned access
module memory_unit #(
  parameter int DATA_SIZE = 64,
  parameter int BYTE_NUM  = DATA_SIZE / 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rd_en,
  input  logic                 wr_en,
  input  logic [BYTE_NUM-1:0]  byte_en,
  input  logic                 signed_ext,
  input  logic [DATA_SIZE-1:0] addr,
  input  logic [DATA_SIZE-1:0] wr_data,
  output logic [DATA_SIZE-1:0] rd_data,
  output logic                 busy,
  output logic                 done,
  output logic                 load_misaligned,
  output logic                 store_misaligned,
  output logic                 access_fault,
  output logic                 wb_cyc,
  output logic                 wb_stb,
  output logic                 wb_we,
  output logic [DATA_SIZE-1:0] wb_addr,
  output logic [BYTE_NUM-1:0]  wb_sel,
  output logic [DATA_SIZE-1:0] wb_dat_o,
  input  logic [DATA_SIZE-1:0] wb_dat_i,
  input  logic                 wb_ack,
  input  logic                 wb_err
);
  localparam int OFF_W = $clog2(BYTE_NUM);

  typedef enum logic [1:0] {ST_IDLE, ST_BUS, ST_DONE, ST_FAULT} state_t;

  state_t state_q, state_d;

  logic [OFF_W-1:0]     off_q;
  logic [BYTE_NUM-1:0]  be_q;
  logic                 sext_q;
  logic                 store_q;
  logic                 err_q;

  logic                 req;
  logic                 accept;
  logic                 bus_end;
  logic [OFF_W-1:0]     offset;
  logic [OFF_W:0]       size;
  logic [OFF_W-1:0]     size_m1;
  logic                 misaligned;
  logic [DATA_SIZE-1:0] shifted;
  logic [BYTE_NUM-1:0]  top_lane;
  logic                 sign_bit;
  logic [DATA_SIZE-1:0] load_val;

  assign req    = rd_en | wr_en;
  assign offset = addr[OFF_W-1:0];

  always_comb begin
    size = '0;
    for (int i = 0; i < BYTE_NUM; i++) begin
      size = size + {{OFF_W{1'b0}}, byte_en[i]};
    end
  end

  // Sizes are powers of two, so "offset mod size" is a mask test; a full-width
  // access wraps size to 0 and the mask becomes all ones, which is still right.
  assign size_m1    = size[OFF_W-1:0] - {{(OFF_W-1){1'b0}}, 1'b1};
  assign misaligned = |(offset & size_m1);

  assign bus_end = (state_q == ST_BUS) && (wb_ack || wb_err);

  // Load path: shift the addressed lanes down, then fill above the top lane.
  assign shifted  = wb_dat_i >> {off_q, 3'b000};
  assign top_lane = be_q & ~{1'b0, be_q[BYTE_NUM-1:1]};

  always_comb begin
    sign_bit = 1'b0;
    load_val = '0;
    for (int i = 0; i < BYTE_NUM; i++) begin
      sign_bit = sign_bit | (top_lane[i] & shifted[8*i+7]);
    end
    for (int i = 0; i < BYTE_NUM; i++) begin
      load_val[8*i +: 8] = be_q[i] ? shifted[8*i +: 8] : {8{sign_bit & sext_q}};
    end
  end

  always_comb begin
    state_d          = state_q;
    accept           = 1'b0;
    busy             = 1'b0;
    done             = 1'b0;
    load_misaligned  = 1'b0;
    store_misaligned = 1'b0;
    access_fault     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy = req;
        if (req) begin
          if (misaligned) begin
            state_d = ST_FAULT;
          end else begin
            accept  = 1'b1;
            state_d = ST_BUS;
          end
        end
      end
      ST_BUS: begin
        busy = 1'b1;
        if (wb_ack || wb_err) state_d = ST_DONE;
      end
      ST_DONE: begin
        done         = 1'b1;
        access_fault = err_q;
        state_d      = ST_IDLE;
      end
      ST_FAULT: begin
        done             = 1'b1;
        load_misaligned  = ~store_q;
        store_misaligned = store_q;
        state_d          = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (reset) busy = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      off_q    <= '0;
      be_q     <= '0;
      sext_q   <= 1'b0;
      store_q  <= 1'b0;
      err_q    <= 1'b0;
      rd_data  <= '0;
      wb_cyc   <= 1'b0;
      wb_stb   <= 1'b0;
      wb_we    <= 1'b0;
      wb_addr  <= '0;
      wb_sel   <= '0;
      wb_dat_o <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && req) store_q <= wr_en;
      if (accept) begin
        off_q    <= offset;
        be_q     <= byte_en;
        sext_q   <= signed_ext;
        wb_cyc   <= 1'b1;
        wb_stb   <= 1'b1;
        wb_we    <= wr_en;
        wb_addr  <= {addr[DATA_SIZE-1:OFF_W], {OFF_W{1'b0}}};
        wb_sel   <= byte_en << offset;
        wb_dat_o <= wr_data << {offset, 3'b000};
      end
      if (bus_end) begin
        wb_cyc <= 1'b0;
        wb_stb <= 1'b0;
        wb_we  <= 1'b0;
        err_q  <= wb_err;
        if (!store_q) rd_data <= wb_err ? '0 : load_val;
      end
    end
  end

endmodule

// File: tb/tb_memory_unit.sv
// Bench for memory_unit: transaction-level model compared every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_memory_unit;
  localparam int DS = 64;
  localparam int BN = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          rd_en = 1'b0, wr_en = 1'b0, signed_ext = 1'b0;
  logic [BN-1:0] byte_en = '0;
  logic [DS-1:0] addr = '0, wr_data = '0, wb_dat_i = '0;
  logic          wb_ack = 1'b0, wb_err = 1'b0;

  logic [DS-1:0] rd_data, wb_addr, wb_dat_o;
  logic [BN-1:0] wb_sel;
  logic          busy, done, load_misaligned, store_misaligned, access_fault;
  logic          wb_cyc, wb_stb, wb_we;

  memory_unit #(.DATA_SIZE(DS)) dut (
    .clock(clock), .reset(reset), .rd_en(rd_en), .wr_en(wr_en),
    .byte_en(byte_en), .signed_ext(signed_ext), .addr(addr), .wr_data(wr_data),
    .rd_data(rd_data), .busy(busy), .done(done),
    .load_misaligned(load_misaligned), .store_misaligned(store_misaligned),
    .access_fault(access_fault), .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
    .wb_addr(wb_addr), .wb_sel(wb_sel), .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i), .wb_ack(wb_ack), .wb_err(wb_err)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Transaction model: phase of the current access plus the expected bus image.
  typedef enum {M_IDLE, M_BUS, M_DONE, M_FAULT} mphase_t;
  mphase_t     m_phase = M_IDLE;
  bit          m_started = 0, m_store = 0, m_err = 0, m_sext = 0, m_cyc = 0, m_we = 0;
  int          m_off = 0, m_sz = 0;
  logic [63:0] m_addr = '0, m_dat = '0, m_rd = '0;
  logic [7:0]  m_sel = '0;

  always @(posedge clock) begin : model
    int          off, sz, sel_wide;
    logic [63:0] v, mask;
    if (reset) begin
      m_started = 1; m_phase = M_IDLE; m_cyc = 0; m_we = 0; m_err = 0;
      m_addr = '0; m_sel = '0; m_dat = '0; m_rd = '0;
    end else begin
      case (m_phase)
        M_IDLE: if (rd_en || wr_en) begin
          off = int'(addr % BN);
          sz  = $countones(byte_en);
          m_store = wr_en;
          if (sz != 0 && (off % sz) != 0) begin
            m_phase = M_FAULT;
          end else begin
            m_phase  = M_BUS;
            m_cyc    = 1; m_we = wr_en;
            m_off    = off; m_sz = sz; m_sext = signed_ext;
            m_addr   = addr - 64'(off);
            sel_wide = int'(byte_en) << off;
            m_sel    = sel_wide[7:0];
            m_dat    = wr_data << (8 * off);
          end
        end
        M_BUS: if (wb_ack || wb_err) begin
          m_cyc = 0; m_we = 0; m_err = wb_err; m_phase = M_DONE;
          if (!m_store) begin
            if (wb_err) begin
              m_rd = '0;
            end else begin
              v    = wb_dat_i >> (8 * m_off);
              mask = (m_sz == 8) ? '1 : ((64'd1 << (8 * m_sz)) - 64'd1);
              v    = v & mask;
              if (m_sext && v[8*m_sz-1]) v = v | ~mask;
              m_rd = v;
            end
          end
        end
        default: m_phase = M_IDLE;
      endcase
    end
  end

  always @(negedge clock) begin
    if (m_started) begin
      chk("busy", busy, !reset && (m_phase == M_BUS || (m_phase == M_IDLE && (rd_en || wr_en))));
      chk("done", done, m_phase == M_DONE || m_phase == M_FAULT);
      chk("load_misaligned", load_misaligned, m_phase == M_FAULT && !m_store);
      chk("store_misaligned", store_misaligned, m_phase == M_FAULT && m_store);
      chk("access_fault", access_fault, m_phase == M_DONE && m_err);
      chk("wb_cyc", wb_cyc, m_cyc);
      chk("wb_stb", wb_stb, m_cyc);
      chk("wb_we", wb_we, m_we);
      chk("rd_data", rd_data, m_rd);
      if (m_cyc) begin
        chk("wb_addr", wb_addr, m_addr);
        chk("wb_sel", wb_sel, m_sel);
        chk("wb_dat_o", wb_dat_o, m_dat);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(posedge clock);
    #2 reset = 1'b0;
    chk("rst_rd_data", rd_data, 64'h0);
    chk("rst_busy", busy, 0);
    chk("rst_cyc", wb_cyc, 0);
    chk("rst_addr", wb_addr, 64'h0);
    chk("rst_sel", wb_sel, 8'h0);
    chk("rst_dat_o", wb_dat_o, 64'h0);
    tick;

    // Signed half load, ack in second bus cycle, done 3 edges after acceptance
    rd_en = 1; byte_en = 8'h03; signed_ext = 1; addr = 64'h1006;
    wb_dat_i = 64'h8421_0000_0000_0000;
    #1 chk("t1_busy_accept", busy, 1);
    tick;
    chk("t1_cyc", wb_cyc, 1);
    chk("t1_addr", wb_addr, 64'h1000);
    chk("t1_sel", wb_sel, 8'hC0);
    chk("t1_we", wb_we, 0);
    tick;
    chk("t1_no_early_done", done, 0);
    wb_ack = 1;
    tick;
    wb_ack = 0; rd_en = 0;
    chk("t1_done", done, 1);
    chk("t1_busy_done", busy, 0);
    chk("t1_rd", rd_data, 64'hFFFF_FFFF_FFFF_8421);
    tick;

    // Word store
    wr_en = 1; byte_en = 8'h0F; signed_ext = 0; addr = 64'h2004;
    wr_data = 64'h0000_0000_DEAD_BEEF;
    tick;
    chk("t2_we", wb_we, 1);
    chk("t2_sel", wb_sel, 8'hF0);
    chk("t2_dat_o", wb_dat_o, 64'hDEAD_BEEF_0000_0000);
    chk("t2_addr", wb_addr, 64'h2000);
    chk("t2_busy", busy, 1);
    tick;
    chk("t2_busy_wait", busy, 1);
    wb_ack = 1;
    tick;
    wb_ack = 0;
    chk("t2_done", done, 1);
    chk("t2_rd_hold", rd_data, 64'hFFFF_FFFF_FFFF_8421);

    // Back-to-back misaligned word load, presented during the Done cycle
    wr_en = 0; rd_en = 1; byte_en = 8'h0F; addr = 64'h1002;
    tick;
    chk("t3_busy", busy, 1);
    chk("t3_cyc_accept", wb_cyc, 0);
    tick;
    chk("t3_done", done, 1);
    chk("t3_load_mis", load_misaligned, 1);
    chk("t3_cyc", wb_cyc, 0);
    chk("t3_rd_hold", rd_data, 64'hFFFF_FFFF_FFFF_8421);
    rd_en = 0;
    tick;

    // Slow slave, unsigned byte load
    rd_en = 1; byte_en = 8'h01; signed_ext = 0; addr = 64'h3003;
    wb_dat_i = 64'h1122_3344_9C55_6677;
    tick;
    for (int i = 0; i < 5; i++) begin
      chk("t4_stb_held", wb_stb, 1);
      chk("t4_busy", busy, 1);
      tick;
    end
    wb_ack = 1;
    tick;
    wb_ack = 0;
    for (n = 0; n < 10 && !done; n++) tick;
    chk("t4_done_seen", done, 1);
    chk("t4_rd", rd_data, 64'h0000_0000_0000_009C);
    rd_en = 0;
    tick;

    // Same byte, sign-extended
    rd_en = 1; signed_ext = 1;
    tick;
    wb_ack = 1;
    tick;
    wb_ack = 0; rd_en = 0;
    chk("t4b_rd", rd_data, 64'hFFFF_FFFF_FFFF_FF9C);
    tick;

    // Store with err and ack together
    wr_en = 1; byte_en = 8'hFF; signed_ext = 0; addr = 64'h4000;
    wr_data = 64'h0123_4567_89AB_CDEF;
    tick;
    wb_ack = 1; wb_err = 1;
    tick;
    wb_ack = 0; wb_err = 0; wr_en = 0;
    chk("t5_done", done, 1);
    chk("t5_fault", access_fault, 1);
    chk("t5_lmis", load_misaligned, 0);
    chk("t5_smis", store_misaligned, 0);
    chk("t5_rd_hold", rd_data, 64'hFFFF_FFFF_FFFF_FF9C);
    tick;

    // Load with err clears rd_data
    rd_en = 1; byte_en = 8'h0F; signed_ext = 1; addr = 64'h4004;
    tick;
    wb_err = 1;
    tick;
    wb_err = 0; rd_en = 0;
    chk("t5b_fault", access_fault, 1);
    chk("t5b_rd", rd_data, 64'h0);
    tick;

    // Reset while the bus cycle is open
    rd_en = 1; byte_en = 8'hFF; addr = 64'h5000; wb_dat_i = 64'h5555_AAAA_5555_AAAA;
    tick;
    chk("t6_cyc_open", wb_cyc, 1);
    reset = 1; rd_en = 0;
    tick;
    reset = 0;
    chk("t6_cyc", wb_cyc, 0);
    chk("t6_stb", wb_stb, 0);
    chk("t6_busy", busy, 0);
    wb_ack = 1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("t6_no_done", done, 0);
    end
    wb_ack = 0;
    tick;

    // Recovery: signed double load, immediate ack
    rd_en = 1; byte_en = 8'hFF; signed_ext = 1; addr = 64'h6008;
    wb_dat_i = 64'hFEDC_BA98_7654_3210;
    tick;
    chk("t7_addr", wb_addr, 64'h6008);
    wb_ack = 1;
    tick;
    wb_ack = 0; rd_en = 0;
    chk("t7_done", done, 1);
    chk("t7_rd", rd_data, 64'hFEDC_BA98_7654_3210);
    repeat (2) tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
